// File: rtl/mesh_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mesh_chk_pkg
//  Description : Shared types for the mesh result checker: FSM state
//                encoding and expected-data mode encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package mesh_chk_pkg;

    // Checker FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Expected-data pattern selectors
    localparam logic [1:0] MODE_REV  = 2'd0;  // data = N-1-i
    localparam logic [1:0] MODE_ID   = 2'd1;  // data = i
    localparam logic [1:0] MODE_ZERO = 2'd2;  // data = 0
    localparam logic [1:0] MODE_XOR  = 2'd3;  // data = i ^ seed

endpackage
`default_nettype wire

// File: rtl/mesh_chk_expect.sv
`default_nettype none
// ============================================================================
//  Module      : mesh_chk_expect
//  Description : Combinational expected-word generator. For PE index i it
//                produces {addr = i, data = f(mode, i, seed)}, with the data
//                field truncated to DATA_WIDTH bits.
//  Ports       : i_idx  - PE index
//                i_mode - pattern selector (see mesh_chk_pkg)
//                i_seed - XOR seed for MODE_XOR
//                o_word - expected {addr, data} word
//  Revision    : 1.0 - initial release
// ============================================================================
module mesh_chk_expect
    import mesh_chk_pkg::*;
#(
    parameter int N          = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0]            i_idx,
    input  logic [1:0]                       i_mode,
    input  logic [DATA_WIDTH-1:0]            i_seed,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_word
);

    // N-1 taken modulo 2**DATA_WIDTH; subtracting the resized index in the
    // same width yields (N-1-i) already truncated to the data field.
    localparam logic [DATA_WIDTH-1:0] NM1 = DATA_WIDTH'(N - 1);

    logic [DATA_WIDTH-1:0] w_idx_d;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_idx_d = DATA_WIDTH'(i_idx);

    always_comb begin
        w_data = '0;
        case (i_mode)
            MODE_REV:  w_data = NM1 - w_idx_d;
            MODE_ID:   w_data = w_idx_d;
            MODE_ZERO: w_data = '0;
            MODE_XOR:  w_data = w_idx_d ^ i_seed;
            default:   w_data = '0;
        endcase
    end

    assign o_word = {i_idx, w_data};

endmodule
`default_nettype wire

// File: rtl/mesh_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : mesh_result_checker
//  Description : Waits SORT_CYCLES after a start, then scans N PE result
//                words (one index per cycle, data returned one cycle later),
//                compares each against a mode-selected expected pattern and
//                reports mismatch count / pass.
//  Ports       : clk, rst (async, active-high)
//                start, abort, mode, seed      - run control
//                rd_idx / rd_data              - PE read port (1-cycle latency)
//                busy, done, pass, err_count   - status
//                first_err_valid/idx/data      - first mismatch record
//  Config      : MESH_CHK_ERR_LOG_EN - when defined, the first mismatch of a
//                run is captured; otherwise first_err_* are tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mesh_result_checker
    import mesh_chk_pkg::*;
#(
    parameter int N           = 256,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int SORT_CYCLES = 112
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [1:0]                       mode,
    input  logic [DATA_WIDTH-1:0]            seed,
    output logic [ADDR_WIDTH-1:0]            rd_idx,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] rd_data,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [ADDR_WIDTH:0]              err_count,
    output logic                             first_err_valid,
    output logic [ADDR_WIDTH-1:0]            first_err_idx,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] first_err_data
);

    // Scan counter runs 0..N: values 0..N-1 drive rd_idx, value N is the
    // drain cycle in which the last returned word is compared.
    localparam int                  CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]    SCAN_LAST = CNT_W'(N);
    // Wait counter is loaded with SORT_CYCLES-1 and counts down to 0.
    localparam int                  WAIT_W    = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0]   WAIT_LOAD = WAIT_W'(SORT_CYCLES - 1);

    state_t                            r_state;
    logic [WAIT_W-1:0]                 r_wait_cnt;
    logic [CNT_W-1:0]                  r_scan_cnt;
    logic [1:0]                        r_mode;
    logic [DATA_WIDTH-1:0]             r_seed;
    logic [CNT_W-1:0]                  r_err_count;
    logic                              r_cmp_en;   // rd_data this cycle belongs to r_cmp_idx
    logic [ADDR_WIDTH-1:0]             r_cmp_idx;

    logic                              w_rd_active;
    logic [ADDR_WIDTH-1:0]             w_rd_idx;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0]  w_exp_word;
    logic                              w_hit;
    logic                              w_abort_go;
    logic                              w_accept;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_abort_go  = abort && (r_state != ST_IDLE);
    assign w_accept    = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_rd_active = (r_state == ST_SCAN) && (r_scan_cnt < SCAN_LAST);
    assign w_rd_idx    = w_rd_active ? r_scan_cnt[ADDR_WIDTH-1:0] : '0;

    mesh_chk_expect #(
        .N          (N),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_expect (
        .i_idx  (r_cmp_idx),
        .i_mode (r_mode),
        .i_seed (r_seed),
        .o_word (w_exp_word)
    );

    // A counted mismatch: compare slot valid, still scanning, not aborted.
    assign w_hit = (r_state == ST_SCAN) && r_cmp_en && !abort && (rd_data != w_exp_word);

    // ------------------------------------------------------------------
    // Main FSM and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_scan_cnt  <= '0;
            r_mode      <= '0;
            r_seed      <= '0;
            r_err_count <= '0;
        end else if (w_abort_go) begin
            // Results are kept; only the run control is dropped.
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_scan_cnt <= '0;
        end else if (w_accept) begin
            r_state     <= ST_WAIT;
            r_wait_cnt  <= WAIT_LOAD;
            r_scan_cnt  <= '0;
            r_mode      <= mode;
            r_seed      <= seed;
            r_err_count <= '0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= ST_SCAN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    end
                end
                ST_SCAN: begin
                    // At most N compares per run, so this cannot wrap.
                    if (w_hit) begin
                        r_err_count <= r_err_count + CNT_W'(1);
                    end
                    if (r_scan_cnt == SCAN_LAST) begin
                        r_state    <= ST_DONE;
                        r_scan_cnt <= '0;
                    end else begin
                        r_scan_cnt <= r_scan_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Compare slot pipeline: tracks which index the incoming rd_data is for
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp_en  <= 1'b0;
            r_cmp_idx <= '0;
        end else begin
            r_cmp_en  <= w_rd_active;
            r_cmp_idx <= w_rd_idx;
        end
    end

    // ------------------------------------------------------------------
    // First-error record
    // ------------------------------------------------------------------
`ifdef MESH_CHK_ERR_LOG_EN
    logic                             r_fe_valid;
    logic [ADDR_WIDTH-1:0]            r_fe_idx;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] r_fe_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fe_valid <= 1'b0;
            r_fe_idx   <= '0;
            r_fe_data  <= '0;
        end else if (w_accept) begin
            r_fe_valid <= 1'b0;
            r_fe_idx   <= '0;
            r_fe_data  <= '0;
        end else if (w_hit && !r_fe_valid) begin
            r_fe_valid <= 1'b1;
            r_fe_idx   <= r_cmp_idx;
            r_fe_data  <= rd_data;
        end
    end

    assign first_err_valid = r_fe_valid;
    assign first_err_idx   = r_fe_idx;
    assign first_err_data  = r_fe_data;
`else
    assign first_err_valid = 1'b0;
    assign first_err_idx   = '0;
    assign first_err_data  = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_idx    = w_rd_idx;
    assign busy      = (r_state == ST_WAIT) || (r_state == ST_SCAN);
    assign done      = (r_state == ST_DONE);
    assign pass      = (r_state == ST_DONE) && (r_err_count == '0);
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_mesh_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mesh_result_checker
//  Description : Self-checking bench for mesh_result_checker with a PE result
//                memory model and a reference model of the expected scan
//                outcome. Honours MESH_CHK_ERR_LOG_EN for first-error checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_result_checker;

    localparam int N   = 256;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int S   = 112;
    localparam int LAT = S + N + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [1:0]     mode;
    logic [DW-1:0]  seed;
    logic [AW-1:0]  rd_idx;
    logic [AW+DW-1:0] rd_data;
    logic           busy;
    logic           done;
    logic           pass;
    logic [AW:0]    err_count;
    logic           first_err_valid;
    logic [AW-1:0]  first_err_idx;
    logic [AW+DW-1:0] first_err_data;

    int total  = 0;
    int passed = 0;

    logic [AW+DW-1:0] mem [N];

    always #5 clk = ~clk;

    // PE result memory: word for rd_idx appears one cycle later
    always @(posedge clk) rd_data <= mem[rd_idx];

    mesh_result_checker #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SORT_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .seed(seed),
        .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_idx(first_err_idx), .first_err_data(first_err_data)
    );

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] ref_data(int i, int m, int sd);
        int v;
        case (m)
            0:       v = N - 1 - i;
            1:       v = i;
            2:       v = 0;
            default: v = i ^ sd;
        endcase
        return DW'(v % 256);
    endfunction

    task automatic fill_ok(input int m, input int sd);
        for (int i = 0; i < N; i++) mem[i] = {AW'(i), ref_data(i, m, sd)};
    endtask

    task automatic model(input int m, input int sd, output int errs,
                         output logic fv, output int fi, output logic [AW+DW-1:0] fd);
        int first;
        errs = 0; first = -1; fd = '0;
        for (int i = 0; i < N; i++) begin
            if (mem[i] !== {AW'(i), ref_data(i, m, sd)}) begin
                errs++;
                if (first < 0) begin first = i; fd = mem[i]; end
            end
        end
`ifdef MESH_CHK_ERR_LOG_EN
        fv = (first >= 0);
        fi = (first >= 0) ? first : 0;
`else
        fv = 1'b0; fi = 0; fd = '0;
`endif
    endtask

    // Start a run and wait for done; also counts rd_idx/busy deviations
    // from the expected schedule (WAIT for S cycles, then rd_idx 0..N-1).
    task automatic run(input int m, input int sd, output int lat, output int sched_bad);
        mode = m[1:0]; seed = DW'(sd); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = -1; sched_bad = 0;
        for (int k = 1; k <= LAT + 20; k++) begin
            @(posedge clk); #1;
            if (rd_idx !== ((k >= S && k <= S + N - 1) ? AW'(k - S) : AW'(0))) sched_bad++;
            if (busy !== (k <= S + N)) sched_bad++;
            if (done) begin lat = k; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 0; abort = 0; mode = 0; seed = 0;
        fill_ok(0, 0);
        repeat (3) @(posedge clk); #1;
        total++; if ({busy, done, pass} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, done, pass}); else passed++;
        total++; if (err_count !== 0) $display("FAIL reset_err_count: got %0d expected 0", err_count); else passed++;
        total++; if (rd_idx !== 0) $display("FAIL reset_rd_idx: got %0d expected 0", rd_idx); else passed++;
        total++; if ({first_err_valid, first_err_idx, first_err_data} !== '0) $display("FAIL reset_first_err: got %h expected 0", {first_err_valid, first_err_idx, first_err_data}); else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_clean_mode0();
        int lat, bad, errs, fi; logic fv; logic [AW+DW-1:0] fd;
        fill_ok(0, 0);
        model(0, 0, errs, fv, fi, fd);
        run(0, 0, lat, bad);
        total++; if (lat !== LAT) $display("FAIL clean_latency: got %0d expected %0d", lat, LAT); else passed++;
        total++; if (bad !== 0) $display("FAIL clean_schedule: got %0d deviations expected 0", bad); else passed++;
        total++; if (pass !== 1'b1 || err_count !== AW'(errs)) $display("FAIL clean_result: got pass=%b err=%0d expected pass=1 err=%0d", pass, err_count, errs); else passed++;
        total++; if (first_err_valid !== 1'b0) $display("FAIL clean_fe_valid: got %b expected 0", first_err_valid); else passed++;
        // results stay stable while DONE is held
        repeat (10) @(posedge clk); #1;
        total++; if (done !== 1'b1 || pass !== 1'b1 || err_count !== 0) $display("FAIL clean_hold: got done=%b pass=%b err=%0d expected 1 1 0", done, pass, err_count); else passed++;
    endtask

    task automatic test_two_errors();
        int lat, bad, errs, fi; logic fv; logic [AW+DW-1:0] fd;
        fill_ok(0, 0);
        mem[17]  = {8'd17, 8'h00};
        mem[200] = {8'd200, 8'h00};
        model(0, 0, errs, fv, fi, fd);
        run(0, 0, lat, bad);
        total++; if (lat !== LAT) $display("FAIL err2_latency: got %0d expected %0d", lat, LAT); else passed++;
        total++; if (err_count !== AW'(errs) || pass !== 1'b0) $display("FAIL err2_result: got err=%0d pass=%b expected err=%0d pass=0", err_count, pass, errs); else passed++;
        total++; if (first_err_valid !== fv || first_err_idx !== AW'(fi) || first_err_data !== fd)
            $display("FAIL err2_first_err: got v=%b idx=%0d data=%h expected v=%b idx=%0d data=%h", first_err_valid, first_err_idx, first_err_data, fv, fi, fd); else passed++;
    endtask

    task automatic test_xor_and_id();
        int lat, bad;
        fill_ok(3, 8'hA5);
        run(3, 8'hA5, lat, bad);
        total++; if (pass !== 1'b1 || err_count !== 0 || lat !== LAT) $display("FAIL xor_pass: got pass=%b err=%0d lat=%0d expected 1 0 %0d", pass, err_count, lat, LAT); else passed++;
        run(1, 0, lat, bad);
        total++; if (err_count !== 9'd256 || pass !== 1'b0) $display("FAIL id_all_wrong: got err=%0d pass=%b expected 256 0", err_count, pass); else passed++;
`ifdef MESH_CHK_ERR_LOG_EN
        total++; if (first_err_idx !== 0 || first_err_data !== 16'h00A5) $display("FAIL id_first_err: got idx=%0d data=%h expected 0 00a5", first_err_idx, first_err_data); else passed++;
`endif
    endtask

    task automatic test_random();
        int lat, bad, errs, fi, m, sd, nc; logic fv; logic [AW+DW-1:0] fd;
        for (int r = 0; r < 5; r++) begin
            m = $urandom_range(0, 3); sd = $urandom_range(0, 255);
            fill_ok(m, sd);
            nc = $urandom_range(0, 6);
            for (int c = 0; c < nc; c++) begin
                int p; p = $urandom_range(0, N - 1);
                mem[p] = mem[p] ^ 16'(($urandom_range(1, 65535)));
            end
            model(m, sd, errs, fv, fi, fd);
            run(m, sd, lat, bad);
            total++; if (lat !== LAT || bad !== 0) $display("FAIL rand%0d_timing: got lat=%0d dev=%0d expected %0d 0", r, lat, bad, LAT); else passed++;
            total++; if (err_count !== AW'(errs) || pass !== (errs == 0)) $display("FAIL rand%0d_result: got err=%0d pass=%b expected err=%0d", r, err_count, pass, errs); else passed++;
            total++; if (first_err_valid !== fv || first_err_idx !== AW'(fi) || first_err_data !== fd)
                $display("FAIL rand%0d_first_err: got v=%b idx=%0d data=%h expected v=%b idx=%0d data=%h", r, first_err_valid, first_err_idx, first_err_data, fv, fi, fd); else passed++;
        end
    endtask

    task automatic test_abort();
        int lat, bad, seen;
        fill_ok(1, 0);  // every index mismatches in mode 0
        mode = 0; seed = 0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (S + 50) @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0 || rd_idx !== 0) $display("FAIL abort_idle: got busy=%b done=%b rd_idx=%0d expected 0 0 0", busy, done, rd_idx); else passed++;
        // indices 0..48 were compared before the abort edge
        total++; if (err_count !== 9'd49) $display("FAIL abort_retained: got %0d expected 49", err_count); else passed++;
        seen = 0;
        for (int k = 0; k < 500; k++) begin @(posedge clk); #1; if (done || busy) seen++; end
        total++; if (seen !== 0) $display("FAIL abort_stays_idle: got %0d active cycles expected 0", seen); else passed++;
        fill_ok(0, 0);
        run(0, 0, lat, bad);
        total++; if (lat !== LAT || pass !== 1'b1) $display("FAIL abort_restart: got lat=%0d pass=%b expected %0d 1", lat, pass, LAT); else passed++;
    endtask

    task automatic test_rst_mid_wait();
        int lat, bad;
        mode = 0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (50) @(posedge clk); #1;
        rst = 1'b1; #1;
        total++; if ({busy, done, pass, err_count, rd_idx, first_err_valid, first_err_idx, first_err_data} !== '0)
            $display("FAIL rst_async: got busy=%b done=%b err=%0d rd_idx=%0d expected all 0", busy, done, err_count, rd_idx); else passed++;
        #1 rst = 1'b0;
        // start sampled on the very first edge after release
        run(0, 0, lat, bad);
        total++; if (lat !== LAT || pass !== 1'b1) $display("FAIL rst_first_start: got lat=%0d pass=%b expected %0d 1", lat, pass, LAT); else passed++;
    endtask

    task automatic test_start_while_busy();
        int lat, errs, fi; logic fv; logic [AW+DW-1:0] fd;
        fill_ok(2, 0);
        mem[5] = 16'h05FF; mem[77] = 16'h1200;  // wrong data, then wrong addr
        model(2, 0, errs, fv, fi, fd);
        mode = 2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = -1;
        for (int k = 1; k <= LAT + 20; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
            start = (k == 10 || k == S + 20 || k == S + N - 1);
            mode  = start ? 2'd1 : 2'd2;  // a relatch would change results
        end
        start = 1'b0; mode = 2;
        total++; if (lat !== LAT) $display("FAIL busy_start_latency: got %0d expected %0d", lat, LAT); else passed++;
        total++; if (err_count !== AW'(errs)) $display("FAIL busy_start_result: got %0d expected %0d", err_count, errs); else passed++;
        total++; if (first_err_valid !== fv || first_err_idx !== AW'(fi) || first_err_data !== fd)
            $display("FAIL busy_start_first_err: got v=%b idx=%0d data=%h expected v=%b idx=%0d data=%h", first_err_valid, first_err_idx, first_err_data, fv, fi, fd); else passed++;
    endtask

    task automatic test_abort_start_in_done();
        int seen;
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1 abort = 1'b0; start = 1'b0;
        total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_start_done: got done=%b busy=%b expected 0 0", done, busy); else passed++;
        total++; if (err_count !== 9'd2) $display("FAIL abort_start_retained: got %0d expected 2", err_count); else passed++;
        seen = 0;
        for (int k = 0; k < 5; k++) begin @(posedge clk); #1; if (busy || done) seen++; end
        total++; if (seen !== 0) $display("FAIL abort_start_no_run: got %0d active cycles expected 0", seen); else passed++;
    endtask

    initial begin
        test_reset();
        test_clean_mode0();
        test_two_errors();
        test_xor_and_id();
        test_random();
        test_abort();
        test_rst_mid_wait();
        test_start_while_busy();
        test_abort_start_in_done();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
